// File: rtl/ace_snoop_pkg.sv
// Shared definitions for the ACE snoop front-end: state encodings, snoop codes,
// log entry layout and the bit positions of the log info word.
package ace_snoop_pkg;

    localparam logic [3:0] DEVIL_EN = 4'd10;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_CAPTURE = 4'd1,
        ST_DFLT_AC = 4'd2,
        ST_DFLT_CR = 4'd3,
        ST_DRAIN   = 4'd4,
        ST_DEVIL   = DEVIL_EN
    } snoop_state_e;

    localparam logic [3:0] SNOOP_READ_ONCE     = 4'd0;
    localparam logic [3:0] SNOOP_READ_SHARED   = 4'd1;
    localparam logic [3:0] SNOOP_READ_UNIQUE   = 4'd7;
    localparam logic [3:0] SNOOP_CLEAN_INVALID = 4'd9;
    localparam logic [3:0] SNOOP_MAKE_INVALID  = 4'd13;

    localparam int INFO_SNOOP_LSB = 0;
    localparam int INFO_ROUTE_BIT = 4;
    localparam int INFO_CNT_LSB   = 8;
    localparam int INFO_CNT_W     = 5;
    localparam int INFO_OVF_BIT   = 16;

    typedef struct packed {
        logic [3:0]  snoop;
        logic        route;
        logic [31:0] addr;
    } log_entry_t;

    localparam int LOG_ENTRY_W = $bits(log_entry_t);

endpackage

// File: rtl/snoop_log_fifo.sv
// Synchronous FIFO holding the snoop log; full pushes are dropped and flagged
// through a sticky overflow bit, and clear wins over push/pop.
module snoop_log_fifo #(
    parameter int WIDTH = 37,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [WIDTH-1:0]           wdata_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic                       overflow_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             ovf_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o    = (count_q == '0);
    assign full_o     = (count_q == CW'(DEPTH));
    assign count_o    = count_q;
    assign overflow_o = ovf_q;
    assign rdata_o    = mem_q[rd_ptr_q];

    // A pop frees the slot in the same cycle, so a full push still lands.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk) begin
        if (do_push && !rst && !clr_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
            if (push_i && !do_push) begin
                ovf_q <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/ace_snoop_frontend.sv
// ACE AC/CR/CD snoop front-end: captures each snoop, routes it to the devil
// responder or a built-in null responder, and logs it for software.
module ace_snoop_frontend
    import ace_snoop_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_ACE_DATA_WIDTH   = 128,
    parameter int C_ACE_ADDR_WIDTH   = 44,
    parameter int LOG_DEPTH          = 16
) (
    input  logic                          ace_aclk,
    input  logic                          ace_areset,
    input  logic                          acvalid,
    output logic                          acready,
    input  logic [C_ACE_ADDR_WIDTH-1:0]   acaddr,
    input  logic [3:0]                    acsnoop,
    output logic                          crvalid,
    input  logic                          crready,
    output logic [4:0]                    crresp,
    output logic                          cdvalid,
    input  logic                          cdready,
    output logic [C_ACE_DATA_WIDTH-1:0]   cddata,
    output logic                          cdlast,
    output logic [3:0]                    o_snoop_state,
    output logic [C_ACE_ADDR_WIDTH-1:0]   o_acaddr,
    output logic [3:0]                    o_acsnoop,
    input  logic                          i_devil_acready,
    input  logic                          i_devil_crvalid,
    input  logic                          i_devil_cdvalid,
    input  logic                          i_devil_cdlast,
    input  logic [4:0]                    i_devil_crresp,
    input  logic [C_ACE_DATA_WIDTH-1:0]   i_devil_rdata,
    input  logic                          i_devil_end,
    input  logic [C_S_AXI_DATA_WIDTH-1:0] i_control_reg,
    input  logic                          i_log_pop,
    input  logic                          i_log_clr,
    output logic [C_S_AXI_DATA_WIDTH-1:0] o_log_addr,
    output logic [C_S_AXI_DATA_WIDTH-1:0] o_log_info,
    output logic [C_S_AXI_DATA_WIDTH-1:0] o_snoop_cnt,
    output logic [C_S_AXI_DATA_WIDTH-1:0] o_devil_cnt
);

    localparam int LCW = $clog2(LOG_DEPTH) + 1;

    snoop_state_e                  state_q;
    logic [C_ACE_ADDR_WIDTH-1:0]   acaddr_q;
    logic [3:0]                    acsnoop_q;
    logic                          acready_q;
    logic                          crvalid_q;
    logic [C_S_AXI_DATA_WIDTH-1:0] snoop_cnt_q;
    logic [C_S_AXI_DATA_WIDTH-1:0] devil_cnt_q;

    logic                          route_devil;
    logic                          in_devil;
    logic                          log_push;
    log_entry_t                    log_wentry;
    log_entry_t                    log_head;
    logic [LOG_ENTRY_W-1:0]        log_rdata;
    logic [LCW-1:0]                log_count;
    logic                          log_full;
    logic                          log_empty;
    logic                          log_ovf;
    logic                          unused_ok;

    // Route is decided once, in CAPTURE; control changes afterwards have no effect.
    assign route_devil = i_control_reg[0] && !i_devil_end;
    assign in_devil    = (state_q == ST_DEVIL);
    assign log_push    = (state_q == ST_CAPTURE);

    always_ff @(posedge ace_aclk) begin
        if (ace_areset) begin
            state_q     <= ST_IDLE;
            acaddr_q    <= '0;
            acsnoop_q   <= '0;
            acready_q   <= 1'b0;
            crvalid_q   <= 1'b0;
            snoop_cnt_q <= '0;
            devil_cnt_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (acvalid) begin
                        acaddr_q  <= acaddr;
                        acsnoop_q <= acsnoop;
                        state_q   <= ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    snoop_cnt_q <= snoop_cnt_q + C_S_AXI_DATA_WIDTH'(1);
                    if (route_devil) begin
                        devil_cnt_q <= devil_cnt_q + C_S_AXI_DATA_WIDTH'(1);
                        state_q     <= ST_DEVIL;
                    end else begin
                        acready_q <= 1'b1;
                        state_q   <= ST_DFLT_AC;
                    end
                end
                ST_DFLT_AC: begin
                    acready_q <= 1'b0;
                    crvalid_q <= 1'b1;
                    state_q   <= ST_DFLT_CR;
                end
                ST_DFLT_CR: begin
                    if (crready) begin
                        crvalid_q <= 1'b0;
                        state_q   <= ST_DRAIN;
                    end
                end
                ST_DEVIL: begin
                    if (i_devil_end) begin
                        state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    acready_q <= 1'b0;
                    crvalid_q <= 1'b0;
                    state_q   <= ST_IDLE;
                end
            endcase
        end
    end

    assign acready = in_devil ? i_devil_acready : acready_q;
    assign crvalid = in_devil ? i_devil_crvalid : crvalid_q;
    assign crresp  = in_devil ? i_devil_crresp  : 5'd0;
    assign cdvalid = in_devil ? i_devil_cdvalid : 1'b0;
    assign cdlast  = in_devil ? i_devil_cdlast  : 1'b0;
    assign cddata  = in_devil ? i_devil_rdata   : '0;

    assign o_snoop_state = state_q;
    assign o_acaddr      = acaddr_q;
    assign o_acsnoop     = acsnoop_q;
    assign o_snoop_cnt   = snoop_cnt_q;
    assign o_devil_cnt   = devil_cnt_q;

    assign log_wentry.snoop = acsnoop_q;
    assign log_wentry.route = route_devil;
    assign log_wentry.addr  = acaddr_q[31:0];

    snoop_log_fifo #(
        .WIDTH (LOG_ENTRY_W),
        .DEPTH (LOG_DEPTH)
    ) u_log (
        .clk        (ace_aclk),
        .rst        (ace_areset),
        .clr_i      (i_log_clr),
        .push_i     (log_push),
        .pop_i      (i_log_pop),
        .wdata_i    (log_wentry),
        .rdata_o    (log_rdata),
        .count_o    (log_count),
        .full_o     (log_full),
        .empty_o    (log_empty),
        .overflow_o (log_ovf)
    );

    assign log_head = log_entry_t'(log_rdata);

    always_comb begin
        o_log_addr = '0;
        o_log_info = '0;
        if (!log_empty) begin
            o_log_addr[31:0]                          = log_head.addr;
            o_log_info[INFO_SNOOP_LSB +: 4]           = log_head.snoop;
            o_log_info[INFO_ROUTE_BIT]                = log_head.route;
            o_log_info[INFO_CNT_LSB +: INFO_CNT_W]    = INFO_CNT_W'(log_count);
            o_log_info[INFO_OVF_BIT]                  = log_ovf;
        end
    end

    assign unused_ok = ^{i_control_reg[C_S_AXI_DATA_WIDTH-1:1], log_full, cdready};

endmodule

// File: tb/tb_ace_snoop_frontend.sv
// Directed-plus-random bench for ace_snoop_frontend against a queue-based model
// of the snoop log and counters.
module tb_ace_snoop_frontend;

    logic         clk = 1'b0;
    logic         ace_areset;
    logic         acvalid;
    logic         acready;
    logic [43:0]  acaddr;
    logic [3:0]   acsnoop;
    logic         crvalid;
    logic         crready;
    logic [4:0]   crresp;
    logic         cdvalid;
    logic         cdready;
    logic [127:0] cddata;
    logic         cdlast;
    logic [3:0]   o_snoop_state;
    logic [43:0]  o_acaddr;
    logic [3:0]   o_acsnoop;
    logic         i_devil_acready;
    logic         i_devil_crvalid;
    logic         i_devil_cdvalid;
    logic         i_devil_cdlast;
    logic [4:0]   i_devil_crresp;
    logic [127:0] i_devil_rdata;
    logic         i_devil_end;
    logic [31:0]  i_control_reg;
    logic         i_log_pop;
    logic         i_log_clr;
    logic [31:0]  o_log_addr;
    logic [31:0]  o_log_info;
    logic [31:0]  o_snoop_cnt;
    logic [31:0]  o_devil_cnt;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  snoop;
        bit          devil;
    } ent_t;

    ent_t        mq[$];
    bit          m_ovf;
    logic [31:0] m_snoop_cnt;
    logic [31:0] m_devil_cnt;

    always #5 clk = ~clk;

    ace_snoop_frontend dut (
        .ace_aclk        (clk),
        .ace_areset      (ace_areset),
        .acvalid         (acvalid),
        .acready         (acready),
        .acaddr          (acaddr),
        .acsnoop         (acsnoop),
        .crvalid         (crvalid),
        .crready         (crready),
        .crresp          (crresp),
        .cdvalid         (cdvalid),
        .cdready         (cdready),
        .cddata          (cddata),
        .cdlast          (cdlast),
        .o_snoop_state   (o_snoop_state),
        .o_acaddr        (o_acaddr),
        .o_acsnoop       (o_acsnoop),
        .i_devil_acready (i_devil_acready),
        .i_devil_crvalid (i_devil_crvalid),
        .i_devil_cdvalid (i_devil_cdvalid),
        .i_devil_cdlast  (i_devil_cdlast),
        .i_devil_crresp  (i_devil_crresp),
        .i_devil_rdata   (i_devil_rdata),
        .i_devil_end     (i_devil_end),
        .i_control_reg   (i_control_reg),
        .i_log_pop       (i_log_pop),
        .i_log_clr       (i_log_clr),
        .o_log_addr      (o_log_addr),
        .o_log_info      (o_log_info),
        .o_snoop_cnt     (o_snoop_cnt),
        .o_devil_cnt     (o_devil_cnt)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic rand_devil();
        i_devil_acready = 1'($urandom);
        i_devil_crvalid = 1'($urandom);
        i_devil_cdvalid = 1'($urandom);
        i_devil_cdlast  = 1'($urandom);
        i_devil_crresp  = 5'($urandom);
        i_devil_rdata   = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_acready"}, acready, 0);
        chk({tag, "_crvalid"}, crvalid, 0);
        chk({tag, "_cdvalid"}, cdvalid, 0);
        chk({tag, "_cdlast"},  cdlast,  0);
        chk({tag, "_crresp"},  crresp,  0);
        chk({tag, "_cddata"},  cddata,  0);
    endtask

    task automatic chk_tracks_devil(input string tag);
        chk({tag, "_acready"}, acready, i_devil_acready);
        chk({tag, "_crvalid"}, crvalid, i_devil_crvalid);
        chk({tag, "_crresp"},  crresp,  i_devil_crresp);
        chk({tag, "_cdvalid"}, cdvalid, i_devil_cdvalid);
        chk({tag, "_cdlast"},  cdlast,  i_devil_cdlast);
        chk({tag, "_cddata"},  cddata,  i_devil_rdata);
    endtask

    function automatic logic [31:0] exp_info();
        if (mq.size() == 0) return 32'd0;
        return 32'(mq[0].snoop) + (mq[0].devil ? 32'd16 : 32'd0)
             + 32'(mq.size()) * 32'd256 + (m_ovf ? 32'd65536 : 32'd0);
    endfunction

    task automatic chk_log(input string tag);
        chk({tag, "_log_addr"},  o_log_addr,  (mq.size() == 0) ? 32'd0 : mq[0].addr);
        chk({tag, "_log_info"},  o_log_info,  exp_info());
        chk({tag, "_snoop_cnt"}, o_snoop_cnt, m_snoop_cnt);
        chk({tag, "_devil_cnt"}, o_devil_cnt, m_devil_cnt);
    endtask

    task automatic mdl_reset();
        mq.delete();
        m_ovf       = 1'b0;
        m_snoop_cnt = '0;
        m_devil_cnt = '0;
    endtask

    task automatic mdl_capture(input logic [43:0] addr, input logic [3:0] snp, input bit devil, input bit pop);
        ent_t e;
        e.addr  = addr[31:0];
        e.snoop = snp;
        e.devil = devil;
        m_snoop_cnt = m_snoop_cnt + 32'd1;
        if (devil) m_devil_cnt = m_devil_cnt + 32'd1;
        if (pop && mq.size() > 0) void'(mq.pop_front());
        if (mq.size() < 16) mq.push_back(e);
        else m_ovf = 1'b1;
    endtask

    task automatic log_pop();
        i_log_pop = 1'b1;
        @(negedge clk);
        i_log_pop = 1'b0;
        if (mq.size() > 0) void'(mq.pop_front());
        chk_log("pop");
    endtask

    task automatic log_clr();
        i_log_clr = 1'b1;
        i_log_pop = 1'($urandom);
        @(negedge clk);
        i_log_clr = 1'b0;
        i_log_pop = 1'b0;
        mq.delete();
        m_ovf = 1'b0;
        chk_log("clr");
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge with it idle again.
    task automatic snoop(input logic [43:0] addr, input logic [3:0] snp, input bit ctrl,
                         input bit dend, input bit pop_cap, input bit rst_cr);
        bit devil;
        int n;
        devil = ctrl && !dend;
        i_control_reg    = $urandom;
        i_control_reg[0] = ctrl;
        i_devil_end      = dend;
        rand_devil();
        acaddr  = addr;
        acsnoop = snp;
        acvalid = 1'b1;
        @(negedge clk);
        chk("cap_state", o_snoop_state, 1);
        chk("cap_addr", o_acaddr, addr);
        chk("cap_snoop", o_acsnoop, snp);
        chk_quiet("cap");
        if (pop_cap) i_log_pop = 1'b1;
        mdl_capture(addr, snp, devil, pop_cap);
        @(negedge clk);
        i_log_pop = 1'b0;
        if (devil) begin
            n = $urandom_range(1, 4);
            for (int i = 0; i < n; i++) begin
                if (i > 0) @(negedge clk);
                rand_devil();
                i_control_reg[0] = 1'($urandom);
                #1;
                chk("dv_state", o_snoop_state, 10);
                chk_tracks_devil("dv");
                acvalid = 1'b0;
            end
            @(negedge clk);
            i_devil_end = 1'b1;
            rand_devil();
            #1;
            chk("dv_end_state", o_snoop_state, 10);
            chk_tracks_devil("dv_end");
            @(negedge clk);
            rand_devil();
            #1;
            chk("dv_drain_state", o_snoop_state, 4);
            chk_quiet("dv_drain");
        end else begin
            chk("ac_state", o_snoop_state, 2);
            chk("ac_acready", acready, 1);
            chk("ac_crvalid", crvalid, 0);
            @(negedge clk);
            acvalid = 1'b0;
            chk("cr_state", o_snoop_state, 3);
            chk("cr_crvalid", crvalid, 1);
            chk("cr_crresp", crresp, 0);
            chk("cr_acready", acready, 0);
            chk("cr_cdvalid", cdvalid, 0);
            if (rst_cr) begin
                ace_areset = 1'b1;
                @(negedge clk);
                ace_areset = 1'b0;
                mdl_reset();
                chk("rst_crvalid", crvalid, 0);
                chk("rst_state", o_snoop_state, 0);
                chk_log("rst");
                i_devil_end = 1'b0;
                return;
            end
            n = $urandom_range(0, 3);
            repeat (n) begin
                rand_devil();
                @(negedge clk);
                chk("crw_crvalid", crvalid, 1);
                chk("crw_crresp", crresp, 0);
                chk("crw_cdvalid", cdvalid, 0);
            end
            crready = 1'b1;
            @(negedge clk);
            crready = 1'b0;
            chk("drain_state", o_snoop_state, 4);
            chk_quiet("drain");
        end
        i_devil_end = 1'b0;
        @(negedge clk);
        chk("idle_state", o_snoop_state, 0);
        chk_quiet("idle");
        chk_log("snp");
    endtask

    function automatic logic [3:0] rand_code();
        logic [3:0] codes [5] = '{4'd0, 4'd1, 4'd7, 4'd9, 4'd13};
        return codes[$urandom_range(0, 4)];
    endfunction

    initial begin
        logic [31:0] first_addr;
        logic [43:0] a;
        ace_areset    = 1'b1;
        acvalid       = 1'b0;
        acaddr        = '0;
        acsnoop       = '0;
        crready       = 1'b0;
        cdready       = 1'b1;
        i_devil_end   = 1'b0;
        i_control_reg = '0;
        i_log_pop     = 1'b0;
        i_log_clr     = 1'b0;
        rand_devil();
        mdl_reset();
        repeat (3) @(negedge clk);
        chk("rst_state0", o_snoop_state, 0);
        chk("rst_acaddr", o_acaddr, 0);
        chk("rst_acsnoop", o_acsnoop, 0);
        chk_quiet("rst0");
        chk_log("rst0");
        ace_areset = 1'b0;
        @(negedge clk);

        // default route, ReadShared
        snoop(44'h0_8000_1000, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t1_info", o_log_info, 32'h0000_0101);
        chk("t1_addr", o_log_addr, 32'h8000_1000);
        chk("t1_cnt", o_snoop_cnt, 32'd1);

        // devil route, CleanInvalid
        snoop(44'h0_1234_5680, 4'd9, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("t2_devil_cnt", o_devil_cnt, 32'd1);

        // devil enabled but end flag already high: default route
        snoop(44'h3_0000_0040, 4'd7, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("t3_devil_cnt", o_devil_cnt, 32'd1);
        chk("t3_snoop_cnt", o_snoop_cnt, 32'd3);

        // overflow
        log_clr();
        for (int i = 0; i < 17; i++) begin
            a = {12'($urandom), $urandom};
            if (i == 0) first_addr = a[31:0];
            snoop(a, rand_code(), 1'($urandom), 1'($urandom), 1'b0, 1'b0);
        end
        chk("ovf_count", o_log_info[12:8], 5'd16);
        chk("ovf_bit", o_log_info[16], 1'b1);
        chk("ovf_head", o_log_addr, first_addr);
        log_clr();
        chk("clr_info", o_log_info, 32'd0);

        // full log with pop during capture
        for (int i = 0; i < 16; i++)
            snoop({12'($urandom), $urandom}, rand_code(), 1'($urandom), 1'b0, 1'b0, 1'b0);
        snoop({12'($urandom), $urandom}, rand_code(), 1'b0, 1'b0, 1'b1, 1'b0);
        chk("fullpop_count", o_log_info[12:8], 5'd16);
        chk("fullpop_ovf", o_log_info[16], 1'b0);

        // random mix
        log_clr();
        for (int i = 0; i < 24; i++) begin
            snoop({12'($urandom), $urandom}, 4'($urandom), 1'($urandom),
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0), 1'b0);
            if ($urandom_range(0, 2) == 0) log_pop();
        end
        for (int i = 0; i < 3; i++) log_pop();

        // reset during DFLT_CR, then a clean snoop
        snoop(44'h0_0000_0abc, 4'd13, 1'b0, 1'b0, 1'b0, 1'b1);
        snoop(44'h0_dead_beef, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("post_rst_cnt", o_snoop_cnt, 32'd1);
        chk("post_rst_info", o_log_info, 32'h0000_0100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
